scoot_bot_walker: RTL

//  Parametrised grid-walking bot controller, successor to the fixed 4-direction scoot bot.

---
 rtl/scoot_bot_walker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/scoot_bot_walker.sv
// Grid-walking bot controller: latches neighbour sensors on each accepted step, keeps a short
// sensor history, picks a move (OR-hold or rotating single priority) and tracks a wrap-around
// position on a WIDTH x HEIGHT grid under a fixed step budget.
// Direction bit order everywhere: [0]=up, [1]=right, [2]=down, [3]=left.

`timescale 1ns/1ps

module scoot_bot_walker #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned HEIGHT     = 10,
  parameter int unsigned HIST_DEPTH = 1,
  parameter int unsigned MAX_STEPS  = 100,
  parameter int unsigned START_X    = 5,
  parameter int unsigned START_Y    = 5,
  localparam int unsigned XW        = $clog2(WIDTH),
  localparam int unsigned YW        = $clog2(HEIGHT),
  localparam int unsigned SW        = $clog2(MAX_STEPS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic          mode,
  input  logic [3:0]    sense,
  output logic [3:0]    move,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [SW-1:0] step_count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    move_q, move_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] count_q, count_d;
  logic [1:0]    heading_q, heading_d;
  logic [3:0]    hist_q [HIST_DEPTH];
  logic [3:0]    hist_d [HIST_DEPTH];

  logic [3:0]    hist_or;
  logic [3:0]    cand;
  logic [3:0]    pick_move;
  logic [1:0]    pick_dir;
  logic [1:0]    scan_dir;
  logic          pick_found;
  logic [3:0]    new_move;
  logic [XW-1:0] x_step;
  logic [YW-1:0] y_step;

  // OR of every held history entry, combined with live sensors to form the candidate set
  always_comb begin
    hist_or = '0;
    for (int i = 0; i < int'(HIST_DEPTH); i++) begin
      hist_or = hist_or | hist_q[i];
    end
    cand = sense | hist_or;
  end

  // Rotating priority scan starting at the current heading; first set candidate wins
  always_comb begin
    pick_move  = '0;
    pick_dir   = heading_q;
    pick_found = 1'b0;
    scan_dir   = '0;
    for (int i = 0; i < 4; i++) begin
      scan_dir = heading_q + 2'(i);
      if (!pick_found && cand[scan_dir]) begin
        pick_found         = 1'b1;
        pick_dir           = scan_dir;
        pick_move[scan_dir] = 1'b1;
      end
    end
  end

  // Wrapped position for the move about to be registered; opposing bits cancel
  always_comb begin
    new_move = mode ? pick_move : cand;
    x_step   = x_q;
    y_step   = y_q;
    if (new_move[1] && !new_move[3]) begin
      x_step = (x_q == XW'(WIDTH - 1)) ? '0 : x_q + XW'(1);
    end else if (new_move[3] && !new_move[1]) begin
      x_step = (x_q == '0) ? XW'(WIDTH - 1) : x_q - XW'(1);
    end
    if (new_move[0] && !new_move[2]) begin
      y_step = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
    end else if (new_move[2] && !new_move[0]) begin
      y_step = (y_q == '0) ? YW'(HEIGHT - 1) : y_q - YW'(1);
    end
  end

  // Next-state: run control, step acceptance, history shift and bookkeeping
  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    heading_d = heading_q;
    for (int i = 0; i < int'(HIST_DEPTH); i++) begin
      hist_d[i] = hist_q[i];
    end

    case (state_q)
      StIdle, StDone: begin
        // start beats a simultaneous step; position and heading carry across runs
        if (start) begin
          state_d = StRun;
          count_d = '0;
          move_d  = '0;
          for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            hist_d[i] = '0;
          end
        end
      end
      StRun: begin
        if (step) begin
          move_d = new_move;
          if (mode && pick_found) begin
            heading_d = pick_dir;
          end
          hist_d[0] = sense;
          for (int i = 1; i < int'(HIST_DEPTH); i++) begin
            hist_d[i] = hist_q[i-1];
          end
          x_d     = x_step;
          y_d     = y_step;
          count_d = (count_q == SW'(MAX_STEPS)) ? count_q : count_q + SW'(1);
          if (count_q == SW'(MAX_STEPS - 1)) begin
            state_d = StDone;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      move_q    <= '0;
      x_q       <= XW'(START_X);
      y_q       <= YW'(START_Y);
      count_q   <= '0;
      heading_q <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
      heading_q <= heading_d;
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign move       = move_q;
  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign step_count = count_q;
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);

endmodule
